// File: rtl/cpu_pkg.sv
// cpu_pkg: shared bundle widths, id_reg field offsets and ALU op bit indices.
package cpu_pkg;
  localparam int ID_TO_EX_W = 152;
  localparam int EX_TO_MEM_W = 71;
  localparam int ID_OP_LSB = 140;
  localparam int ID_RES_FROM_MEM = 139;
  localparam int ID_NEED_UI5 = 138;
  localparam int ID_SRC1_IS_PC = 137;
  localparam int ID_SRC2_IS_IMM = 136;
  localparam int ID_SRC2_IS_4 = 135;
  localparam int ID_GR_WE = 134;
  localparam int ID_MEM_WE = 133;
  localparam int ID_DEST_LSB = 128;
  localparam int ID_IMM_LSB = 96;
  localparam int ID_RJ_LSB = 64;
  localparam int ID_RKD_LSB = 32;
  localparam int ID_PC_LSB = 0;
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_SLT = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_NOR = 5;
  localparam int ALU_OR = 6;
  localparam int ALU_XOR = 7;
  localparam int ALU_SLL = 8;
  localparam int ALU_SRL = 9;
  localparam int ALU_SRA = 10;
  localparam int ALU_LUI = 11;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: decode/memory handshakes, data-SRAM port and hazard taps of EX.
// EX_FWD_EN adds the EX bypass outputs.
interface ex_stage_if;
  import cpu_pkg::*;
  logic id_to_ex_valid;
  logic ex_allowin;
  logic [ID_TO_EX_W-1:0] id_reg;
  logic mem_allowin;
  logic ex_to_mem_valid;
  logic [EX_TO_MEM_W-1:0] ex_reg;
  logic data_sram_en;
  logic [3:0] data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic ex_valid_o;
  logic ex_gr_we_o;
  logic [4:0] ex_dest_o;
`ifdef EX_FWD_EN
  logic [31:0] ex_fwd_wdata;
  logic ex_res_from_mem;
`endif
  modport slave (
    input id_to_ex_valid, id_reg, mem_allowin,
    output ex_allowin, ex_to_mem_valid, ex_reg, data_sram_en, data_sram_we,
    output data_sram_addr, data_sram_wdata, ex_valid_o, ex_gr_we_o, ex_dest_o
`ifdef EX_FWD_EN
    , output ex_fwd_wdata, ex_res_from_mem
`endif
  );
  modport master (
    output id_to_ex_valid, id_reg, mem_allowin,
    input ex_allowin, ex_to_mem_valid, ex_reg, data_sram_en, data_sram_we,
    input data_sram_addr, data_sram_wdata, ex_valid_o, ex_gr_we_o, ex_dest_o
`ifdef EX_FWD_EN
    , input ex_fwd_wdata, ex_res_from_mem
`endif
  );
endinterface

// File: rtl/ex_stage_alu.sv
// alu: combinational 12-operation ALU selected by a one-hot op vector.
module alu
  import cpu_pkg::*;
(
  input  logic [11:0] alu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result
);
  logic [31:0] sra_res;
  assign sra_res = $signed(src1) >>> src2[4:0];
  assign result = ({32{alu_op[ALU_ADD]}}  & (src1 + src2))
                | ({32{alu_op[ALU_SUB]}}  & (src1 - src2))
                | ({32{alu_op[ALU_SLT]}}  & {31'b0, $signed(src1) < $signed(src2)})
                | ({32{alu_op[ALU_SLTU]}} & {31'b0, src1 < src2})
                | ({32{alu_op[ALU_AND]}}  & (src1 & src2))
                | ({32{alu_op[ALU_NOR]}}  & ~(src1 | src2))
                | ({32{alu_op[ALU_OR]}}   & (src1 | src2))
                | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2))
                | ({32{alu_op[ALU_SLL]}}  & (src1 << src2[4:0]))
                | ({32{alu_op[ALU_SRL]}}  & (src1 >> src2[4:0]))
                | ({32{alu_op[ALU_SRA]}}  & sra_res)
                | ({32{alu_op[ALU_LUI]}}  & src2);
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage; latches the decode bundle, runs the ALU, issues data-SRAM requests.
// Define EX_FWD_EN to export the EX bypass value and load-use flag to decode.
module ex_stage
  import cpu_pkg::*;
(
  input logic clk,
  input logic resetn,
  ex_stage_if.slave bus
);
  logic ex_valid_q, ex_valid_d;
  logic [ID_TO_EX_W-1:0] payload_q, payload_d;
  logic ex_allowin;
  logic [31:0] src1, src2, alu_result;
  logic res_from_mem, mem_we;
  logic unused_folded;
  assign ex_allowin = !ex_valid_q || bus.mem_allowin;
  always_comb begin
    ex_valid_d = ex_allowin ? bus.id_to_ex_valid : ex_valid_q;
    payload_d = (bus.id_to_ex_valid && ex_allowin) ? bus.id_reg : payload_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q <= 1'b0;
      payload_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      payload_q <= payload_d;
    end
  end
  // decode has already folded these into imm
  assign unused_folded = ^{payload_q[ID_NEED_UI5], payload_q[ID_SRC2_IS_4]};
  assign src1 = payload_q[ID_SRC1_IS_PC] ? payload_q[ID_PC_LSB +: 32] : payload_q[ID_RJ_LSB +: 32];
  assign src2 = payload_q[ID_SRC2_IS_IMM] ? payload_q[ID_IMM_LSB +: 32] : payload_q[ID_RKD_LSB +: 32];
  alu u_alu (
    .alu_op(payload_q[ID_OP_LSB +: 12]),
    .src1(src1),
    .src2(src2),
    .result(alu_result)
  );
  assign res_from_mem = payload_q[ID_RES_FROM_MEM];
  assign mem_we = payload_q[ID_MEM_WE];
  assign bus.ex_allowin = ex_allowin;
  assign bus.ex_to_mem_valid = ex_valid_q;
  assign bus.ex_reg = {res_from_mem, payload_q[ID_GR_WE], payload_q[ID_DEST_LSB +: 5],
                       alu_result, payload_q[ID_PC_LSB +: 32]};
  assign bus.data_sram_en = ex_valid_q && (res_from_mem || mem_we) && bus.mem_allowin;
  assign bus.data_sram_we = {4{ex_valid_q && mem_we && bus.mem_allowin}};
  assign bus.data_sram_addr = alu_result;
  assign bus.data_sram_wdata = payload_q[ID_RKD_LSB +: 32];
  assign bus.ex_valid_o = ex_valid_q;
  assign bus.ex_gr_we_o = payload_q[ID_GR_WE];
  assign bus.ex_dest_o = payload_q[ID_DEST_LSB +: 5];
`ifdef EX_FWD_EN
  assign bus.ex_fwd_wdata = alu_result;
  assign bus.ex_res_from_mem = ex_valid_q && res_from_mem;
`endif
endmodule
